vec_scalar_regfile_sb: RTL and testbench
========================================

Name: vec_scalar_regfile_sb

Overview:
Parametrised vector/scalar register file for the SIMD datapath: LANES x WIDTH vector registers plus a scalar file whose top index reads the live PC. Adds per-lane write masking, a per-register pending scoreboard for in-flight producers, and a sequenced bulk-clear engine. Sits between decode (read ports, hazard check) and writeback (write port).

Parameters:
LANES, 16, number of vector lanes
WIDTH, 32, bits per lane / scalar register
NUM_VREGS, 16, vector registers (power of 2, >=2)
NUM_SREGS, 16, scalar indices; index NUM_SREGS-1 is the PC alias, not stored
AW, $clog2(max(NUM_VREGS,NUM_SREGS)), register address width (derived)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
ra1, ra2  in  AW  read addresses
rsel_v  in  1  read mode: 1 vector, 0 scalar (both ports)
pc_in  in  WIDTH  current PC, returned for scalar index NUM_SREGS-1
rd1, rd2  out  LANES*WIDTH  read data, lane k at bits [k*WIDTH +: WIDTH]
busy1, busy2  out  1  read target has pending producer
we  in  1  write enable
wsel_v  in  1  write target: 1 vector, 0 scalar
wa  in  AW  write address
wd  in  LANES*WIDTH  write data (scalar uses lane LANES-1)
wmask  in  LANES  per-lane write enable (vector only)
sb_set  in  1  mark register pending
sb_v  in  1  pending target file: 1 vector, 0 scalar
sb_addr  in  AW  pending target address
clr_req  in  1  start bulk clear
clr_busy  out  1  clear engine active

Behaviour:
- Reset (async): all vector and scalar registers 0, all pending bits 0, FSM IDLE, clr_busy 0, counter 0.
- Reads combinational. Vector mode: rd = vreg[ra] (ra >= NUM_VREGS reads 0). Scalar mode: lane LANES-1 = sreg[ra], or pc_in when ra == NUM_SREGS-1; lanes LANES-2..0 = 0.
- busyN = pending bit of the selected file/address; always 0 for PC alias and out-of-range addresses.
- Vector write (we & wsel_v, IDLE): lanes with wmask[k]=1 updated; others hold. wmask=0 still a completed write.
- Scalar write (we & !wsel_v, IDLE): sreg[wa] <= wd lane LANES-1; wmask ignored; wa == NUM_SREGS-1 or out of range discarded.
- Scoreboard: accepted write clears pending[target]. sb_set sets pending[target]. Same target same cycle: set wins (bit stays 1). Different targets: both apply.
- Clear FSM: IDLE -> CLEAR on clr_req (entering cycle also zeros all pending bits). In CLEAR, per cycle: vreg[cnt] <= 0, and sreg[cnt] <= 0 if cnt < NUM_SREGS-1; cnt++. After cnt == NUM_VREGS-1 zeroed -> IDLE, cnt <= 0. clr_busy = (state == CLEAR): high NUM_VREGS cycles starting the cycle after clr_req sampled.
- During CLEAR: we and sb_set ignored (upstream must stall on clr_busy); clr_req ignored. Reads return current (partially cleared) contents; busy1/2 = 0.
- clr_req with we in same IDLE cycle: write performed, CLEAR entered; that register is zeroed later in sequence.
- rst mid-CLEAR: immediate return to reset state.

Optional Feature:
VRF_BYPASS_EN: defined -> write-to-read forwarding: when an accepted write this cycle targets the read file/address, rdN shows post-write value combinationally (vector: wd lanes where wmask=1, stored lanes elsewhere; scalar: wd lane LANES-1) and busyN = 0 unless sb_set hits the same target. Not defined -> reads return pre-edge contents; new value visible cycle after edge.

Test Plan:
- Reset, read v3 vector and s2 scalar -> all lanes 0, busy 0; scalar ra=15, pc_in=0x100 -> rd1 lane15 = 0x100, other lanes 0.
- Write v2 wd lanes=k+1, wmask=0x00FF, then read v2 -> lanes 0..7 = 1..8, lanes 8..15 = 0.
- sb_set vector addr 5; next cycle ra1=5 vector -> busy1=1; write v5 -> busy1=0 next cycle; same-cycle sb_set+write on v5 -> busy1 stays 1.
- Scalar write wa=15 wd=0xDEAD -> read s15 still returns pc_in; s14 write 0xBEEF reads 0xBEEF.
- Fill v0..v15 nonzero, pulse clr_req -> clr_busy high exactly 16 cycles; we asserted mid-clear has no effect; all regs 0 after.
- With VRF_BYPASS_EN: write v1 0xA5 all lanes while ra1=1 -> rd1 = 0xA5 same cycle; without -> old value that cycle, 0xA5 next.

Source files
------------

// File: rtl/vec_scalar_regfile_sb.sv
// SIMD vector/scalar register file: masked lane writes, per-register pending scoreboard, sequenced bulk clear.
// Define VRF_BYPASS_EN to forward an accepted same-cycle write onto the read ports.
module vec_scalar_regfile_sb #(
  parameter int LANES     = 16,
  parameter int WIDTH     = 32,
  parameter int NUM_VREGS = 16,
  parameter int NUM_SREGS = 16,
  parameter int AW        = $clog2((NUM_VREGS > NUM_SREGS) ? NUM_VREGS : NUM_SREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          ra1,
  input  logic [AW-1:0]          ra2,
  input  logic                   rsel_v,
  input  logic [WIDTH-1:0]       pc_in,
  output logic [LANES*WIDTH-1:0] rd1,
  output logic [LANES*WIDTH-1:0] rd2,
  output logic                   busy1,
  output logic                   busy2,
  input  logic                   we,
  input  logic                   wsel_v,
  input  logic [AW-1:0]          wa,
  input  logic [LANES*WIDTH-1:0] wd,
  input  logic [LANES-1:0]       wmask,
  input  logic                   sb_set,
  input  logic                   sb_v,
  input  logic [AW-1:0]          sb_addr,
  input  logic                   clr_req,
  output logic                   clr_busy
);

  localparam int LW     = LANES * WIDTH;
  localparam int VW     = $clog2(NUM_VREGS);
  localparam int SW     = $clog2(NUM_SREGS);
  localparam int PC_IDX = NUM_SREGS - 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state;
  logic [VW-1:0]        cnt;
  logic [LW-1:0]        vreg [NUM_VREGS];
  logic [WIDTH-1:0]     sreg [NUM_SREGS-1];
  logic [NUM_VREGS-1:0] pend_v;
  logic [NUM_SREGS-2:0] pend_s;

  logic idle, wr_v, wr_s, set_v, set_s;

  always_comb begin
    idle  = (state == IDLE);
    wr_v  = idle & we & wsel_v & (int'(wa) < NUM_VREGS);
    wr_s  = idle & we & ~wsel_v & (int'(wa) < PC_IDX);
    set_v = idle & sb_set & sb_v & (int'(sb_addr) < NUM_VREGS);
    set_s = idle & sb_set & ~sb_v & (int'(sb_addr) < PC_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      pend_v <= '0;
      pend_s <= '0;
      for (int unsigned i = 0; i < NUM_VREGS; i++) vreg[i] <= '0;
      for (int unsigned i = 0; i < NUM_SREGS - 1; i++) sreg[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_v) begin
            for (int unsigned k = 0; k < LANES; k++)
              if (wmask[k]) vreg[wa[VW-1:0]][k*WIDTH +: WIDTH] <= wd[k*WIDTH +: WIDTH];
            pend_v[wa[VW-1:0]] <= 1'b0;
          end
          if (wr_s) begin
            sreg[wa[SW-1:0]]   <= wd[LW-1 -: WIDTH];
            pend_s[wa[SW-1:0]] <= 1'b0;
          end
          // Later assignments take priority: set beats write-clear, clear entry beats both.
          if (set_v) pend_v[sb_addr[VW-1:0]] <= 1'b1;
          if (set_s) pend_s[sb_addr[SW-1:0]] <= 1'b1;
          if (clr_req) begin
            pend_v <= '0;
            pend_s <= '0;
            cnt    <= '0;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          vreg[cnt] <= '0;
          if (int'(cnt) < PC_IDX) sreg[SW'(cnt)] <= '0;
          if (cnt == '1) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + VW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [AW-1:0] ra   [2];
  logic [LW-1:0] rd   [2];
  logic          busy [2];

  always_comb begin
    ra[0] = ra1;
    ra[1] = ra2;
    for (int unsigned p = 0; p < 2; p++) begin
      rd[p]   = '0;
      busy[p] = 1'b0;
      if (rsel_v) begin
        if (int'(ra[p]) < NUM_VREGS) begin
          rd[p]   = vreg[ra[p][VW-1:0]];
          busy[p] = pend_v[ra[p][VW-1:0]];
`ifdef VRF_BYPASS_EN
          if (wr_v && (wa == ra[p])) begin
            for (int unsigned k = 0; k < LANES; k++)
              if (wmask[k]) rd[p][k*WIDTH +: WIDTH] = wd[k*WIDTH +: WIDTH];
            busy[p] = set_v && (sb_addr == ra[p]);
          end
`endif
        end
      end else if (int'(ra[p]) == PC_IDX) begin
        rd[p][LW-1 -: WIDTH] = pc_in;
      end else if (int'(ra[p]) < PC_IDX) begin
        rd[p][LW-1 -: WIDTH] = sreg[ra[p][SW-1:0]];
        busy[p]              = pend_s[ra[p][SW-1:0]];
`ifdef VRF_BYPASS_EN
        if (wr_s && (wa == ra[p])) begin
          rd[p][LW-1 -: WIDTH] = wd[LW-1 -: WIDTH];
          busy[p]              = set_s && (sb_addr == ra[p]);
        end
`endif
      end
      if (!idle) busy[p] = 1'b0;
    end
  end

  assign rd1      = rd[0];
  assign rd2      = rd[1];
  assign busy1    = busy[0];
  assign busy2    = busy[1];
  assign clr_busy = (state == CLEAR);

endmodule

// File: tb/tb_vec_scalar_regfile_sb.sv
// Self-checking bench for vec_scalar_regfile_sb: directed steps plus random traffic against a lane-array model.
module tb_vec_scalar_regfile_sb;
  localparam int LANES = 16;
  localparam int WIDTH = 32;
  localparam int NV    = 16;
  localparam int NS    = 16;
  localparam int AW    = 4;
  localparam int LW    = LANES * WIDTH;

  logic          clk, rst;
  logic [AW-1:0] ra1, ra2, wa, sb_addr;
  logic          rsel_v, we, wsel_v, sb_set, sb_v, clr_req;
  logic [WIDTH-1:0] pc_in;
  logic [LW-1:0] rd1, rd2, wd;
  logic          busy1, busy2, clr_busy;
  logic [LANES-1:0] wmask;

  vec_scalar_regfile_sb #(
    .LANES(LANES), .WIDTH(WIDTH), .NUM_VREGS(NV), .NUM_SREGS(NS)
  ) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rsel_v(rsel_v), .pc_in(pc_in),
    .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2), .we(we), .wsel_v(wsel_v),
    .wa(wa), .wd(wd), .wmask(wmask), .sb_set(sb_set), .sb_v(sb_v), .sb_addr(sb_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: each register is an array of lane values.
  logic [WIDTH-1:0] mv [NV][LANES];
  logic [WIDTH-1:0] ms [NS-1];
  bit               mpv [NV];
  bit               mps [NS-1];
  int               m_clr_idx;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int r = 0; r < NV; r++) begin
      mpv[r] = 0;
      for (int k = 0; k < LANES; k++) mv[r][k] = '0;
    end
    for (int r = 0; r < NS - 1; r++) begin
      ms[r]  = '0;
      mps[r] = 0;
    end
    m_clr_idx = -1;
  endfunction

  function automatic logic [LW-1:0] m_read(input logic [AW-1:0] a, input logic vmode);
    logic [LW-1:0] r;
    int ai;
    r  = '0;
    ai = int'(a);
    if (vmode) begin
      if (ai < NV) for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = mv[ai][k];
`ifdef VRF_BYPASS_EN
      if (m_clr_idx < 0 && we && wsel_v && int'(wa) == ai && ai < NV)
        for (int k = 0; k < LANES; k++) if (wmask[k]) r[k*WIDTH +: WIDTH] = wd[k*WIDTH +: WIDTH];
`endif
    end else begin
      if (ai == NS - 1) r[LW-1 -: WIDTH] = pc_in;
      else if (ai < NS - 1) begin
        r[LW-1 -: WIDTH] = ms[ai];
`ifdef VRF_BYPASS_EN
        if (m_clr_idx < 0 && we && !wsel_v && int'(wa) == ai) r[LW-1 -: WIDTH] = wd[LW-1 -: WIDTH];
`endif
      end
    end
    return r;
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a, input logic vmode);
    logic b;
    int ai;
    ai = int'(a);
    if (m_clr_idx >= 0) return 1'b0;
    if (vmode) begin
      if (ai >= NV) return 1'b0;
      b = mpv[ai];
`ifdef VRF_BYPASS_EN
      if (we && wsel_v && int'(wa) == ai) b = sb_set && sb_v && int'(sb_addr) == ai;
`endif
    end else begin
      if (ai >= NS - 1) return 1'b0;
      b = mps[ai];
`ifdef VRF_BYPASS_EN
      if (we && !wsel_v && int'(wa) == ai) b = sb_set && !sb_v && int'(sb_addr) == ai;
`endif
    end
    return b;
  endfunction

  function automatic void m_edge();
    int wi, si;
    wi = int'(wa);
    si = int'(sb_addr);
    if (m_clr_idx >= 0) begin
      for (int k = 0; k < LANES; k++) mv[m_clr_idx][k] = '0;
      if (m_clr_idx < NS - 1) ms[m_clr_idx] = '0;
      m_clr_idx++;
      if (m_clr_idx == NV) m_clr_idx = -1;
    end else begin
      if (we && wsel_v && wi < NV) begin
        for (int k = 0; k < LANES; k++) if (wmask[k]) mv[wi][k] = wd[k*WIDTH +: WIDTH];
        mpv[wi] = 0;
      end
      if (we && !wsel_v && wi < NS - 1) begin
        ms[wi]  = wd[LW-1 -: WIDTH];
        mps[wi] = 0;
      end
      if (sb_set && sb_v && si < NV) mpv[si] = 1;
      if (sb_set && !sb_v && si < NS - 1) mps[si] = 1;
      if (clr_req) begin
        for (int r = 0; r < NV; r++) mpv[r] = 0;
        for (int r = 0; r < NS - 1; r++) mps[r] = 0;
        m_clr_idx = 0;
      end
    end
  endfunction

  // Compare every output against the model, then advance one clock edge.
  task automatic cycle();
    #1;
    chk("rd1", rd1, m_read(ra1, rsel_v));
    chk("rd2", rd2, m_read(ra2, rsel_v));
    chk("busy1", LW'(busy1), LW'(m_busy(ra1, rsel_v)));
    chk("busy2", LW'(busy2), LW'(m_busy(ra2, rsel_v)));
    chk("clr_busy", LW'(clr_busy), LW'(m_clr_idx >= 0));
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    we = 1'b0; wsel_v = 1'b0; wa = '0; wd = '0; wmask = '0;
    sb_set = 1'b0; sb_v = 1'b0; sb_addr = '0; clr_req = 1'b0;
  endtask

  task automatic rand_wd();
    for (int k = 0; k < LANES; k++) wd[k*WIDTH +: WIDTH] = $urandom;
  endtask

  function automatic logic [LW-1:0] top_lane(input logic [WIDTH-1:0] v);
    logic [LW-1:0] r;
    r = '0;
    r[LW-1 -: WIDTH] = v;
    return r;
  endfunction

  logic [LW-1:0] exp_v;
  int            nbusy;

  initial begin
    rst = 1'b1;
    quiet();
    ra1 = '0; ra2 = '0; rsel_v = 1'b1; pc_in = 32'h100;
    m_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and PC alias
    ra1 = 4'd3; ra2 = 4'd2; rsel_v = 1'b1;
    #1 chk("rst_v3", rd1, '0);
    chk("rst_busy1", LW'(busy1), '0);
    chk("rst_clr_busy", LW'(clr_busy), '0);
    rsel_v = 1'b0;
    #1 chk("rst_s2", rd2, '0);
    ra1 = 4'd15; pc_in = 32'h100;
    #1 chk("pc_alias", rd1, top_lane(32'h100));
    cycle();

    // Masked vector write
    we = 1'b1; wsel_v = 1'b1; wa = 4'd2; wmask = 16'h00FF;
    for (int k = 0; k < LANES; k++) wd[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
    cycle();
    quiet();
    ra1 = 4'd2; rsel_v = 1'b1;
    exp_v = '0;
    for (int k = 0; k < 8; k++) exp_v[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
    #1 chk("masked_v2", rd1, exp_v);
    cycle();

    // Scoreboard set, clear by write, set-wins on collision
    sb_set = 1'b1; sb_v = 1'b1; sb_addr = 4'd5; ra1 = 4'd5; rsel_v = 1'b1;
    cycle();
    quiet();
    #1 chk("sb_pending", LW'(busy1), LW'(1'b1));
    we = 1'b1; wsel_v = 1'b1; wa = 4'd5; wmask = '1; rand_wd();
    cycle();
    quiet();
    #1 chk("sb_cleared", LW'(busy1), '0);
    we = 1'b1; wsel_v = 1'b1; wa = 4'd5; wmask = '1; rand_wd();
    sb_set = 1'b1; sb_v = 1'b1; sb_addr = 4'd5;
    cycle();
    quiet();
    #1 chk("sb_set_wins", LW'(busy1), LW'(1'b1));
    cycle();

    // Scalar writes: PC alias discarded, s14 stored
    we = 1'b1; wsel_v = 1'b0; wa = 4'd15; wd = top_lane(32'hDEAD);
    cycle();
    quiet();
    rsel_v = 1'b0; ra1 = 4'd15; pc_in = 32'h1234;
    #1 chk("s15_is_pc", rd1, top_lane(32'h1234));
    we = 1'b1; wsel_v = 1'b0; wa = 4'd14; wd = top_lane(32'hBEEF); wmask = '0;
    cycle();
    quiet();
    ra1 = 4'd14;
    #1 chk("s14_beef", rd1, top_lane(32'hBEEF));
    cycle();

    // Write-to-read timing on v1
    we = 1'b1; wsel_v = 1'b1; wa = 4'd1; wmask = '1; ra1 = 4'd1; rsel_v = 1'b1;
    for (int k = 0; k < LANES; k++) wd[k*WIDTH +: WIDTH] = 32'hA5;
    exp_v = wd;
    cycle();
    quiet();
    #1 chk("v1_a5_next", rd1, exp_v);
    cycle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      we      = 1'($urandom_range(0, 1));
      wsel_v  = 1'($urandom_range(0, 1));
      wa      = AW'($urandom_range(0, 15));
      wmask   = LANES'($urandom);
      rand_wd();
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_v    = 1'($urandom_range(0, 1));
      sb_addr = AW'($urandom_range(0, 15));
      ra1     = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
      ra2     = AW'($urandom_range(0, 15));
      rsel_v  = 1'($urandom_range(0, 1));
      pc_in   = $urandom;
      cycle();
    end

    // Bulk clear: fill, then clear with a same-cycle write, blocked traffic mid-clear
    quiet();
    for (int r = 0; r < NV; r++) begin
      we = 1'b1; wsel_v = 1'b1; wa = AW'(r); wmask = '1; rand_wd(); wd[0] = 1'b1;
      sb_set = 1'b1; sb_v = 1'b0; sb_addr = AW'(r);
      cycle();
    end
    for (int r = 0; r < NS - 1; r++) begin
      we = 1'b1; wsel_v = 1'b0; wa = AW'(r); rand_wd(); wd[LW-1] = 1'b1;
      sb_set = 1'b1; sb_v = 1'b1; sb_addr = AW'(r);
      cycle();
    end
    quiet();
    clr_req = 1'b1; we = 1'b1; wsel_v = 1'b1; wa = 4'd3; wmask = '1; rand_wd();
    cycle();
    quiet();
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (!clr_busy) break;
      nbusy++;
      quiet();
      ra1 = AW'(i % NV); ra2 = AW'((i + 7) % NV); rsel_v = 1'b1;
      if (i == 10) begin
        we = 1'b1; wsel_v = 1'b1; wa = 4'd0; wmask = '1; wd = '1;
        sb_set = 1'b1; sb_v = 1'b1; sb_addr = 4'd2; clr_req = 1'b1;
      end
      cycle();
    end
    quiet();
    chk("clr_busy_cycles", LW'(nbusy), LW'(16));
    for (int r = 0; r < NV; r++) begin
      ra1 = AW'(r); ra2 = AW'(r); rsel_v = 1'b1;
      #1 chk("post_clr_v", rd1, '0);
      chk("post_clr_vbusy", LW'(busy1), '0);
      rsel_v = 1'b0;
      #1 chk("post_clr_s", rd2, (r == NS - 1) ? top_lane(pc_in) : '0);
    end
    cycle();

    // Reset in the middle of a clear
    we = 1'b1; wsel_v = 1'b1; wa = 4'd9; wmask = '1; rand_wd(); wd[0] = 1'b1;
    cycle();
    quiet();
    clr_req = 1'b1;
    cycle();
    quiet();
    cycle();
    cycle();
    #2 rst = 1'b1;
    m_reset();
    ra1 = 4'd9; rsel_v = 1'b1;
    #1 chk("rst_mid_clr_busy", LW'(clr_busy), '0);
    chk("rst_mid_clr_v9", rd1, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
